// File: rtl/nb_sign_unit_seq_pkg.sv
// nb_sign_pkg: shared encodings for the digit-serial sign unit.
//   mode_t  : operation select sampled on accept
//   state_t : control FSM states
package nb_sign_pkg;
  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_ABS  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/nb_sign_unit_seq_if.sv
// nb_sign_unit_seq_if: operand/result handshake bundle of the sign unit.
//   in_valid/in_ready/a/mode     : operand side
//   out_valid/out_ready/y/ovf/zero : result side
//   slave  : the sign unit
//   master : the producer/consumer driving it
interface nb_sign_unit_seq_if #(
  parameter int N = 5
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] y;
  logic         ovf;
  logic         zero;

  modport slave (
    input  in_valid, a, mode, out_ready,
    output in_ready, out_valid, y, ovf, zero
  );

  modport master (
    output in_valid, a, mode, out_ready,
    input  in_ready, out_valid, y, ovf, zero
  );
endinterface

// File: rtl/nb_sign_unit_seq_digit_cinc.sv
// nb_digit_cinc: one W-bit digit of a rippled two's-complement negation.
//   d    : operand digit
//   inv  : invert the digit before adding
//   cin  : carry from the previous (less significant) digit
//   r    : result digit
//   cout : carry into the next digit
module nb_digit_cinc #(
  parameter int W = 1
) (
  input  logic [W-1:0] d,
  input  logic         inv,
  input  logic         cin,
  output logic [W-1:0] r,
  output logic         cout
);
  logic [W-1:0] dx;

  assign dx        = inv ? ~d : d;
  assign {cout, r} = {1'b0, dx} + {{W{1'b0}}, cin};
endmodule

// File: rtl/nb_sign_unit_seq.sv
// nb_sign_unit_seq: digit-serial pass / negate / abs of an N-bit signed word,
// W bits per clock, LSB digit first.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : operand/result handshake (slave side)
module nb_sign_unit_seq
  import nb_sign_pkg::*;
#(
  parameter int N = 5,
  parameter int W = 1
) (
  input logic              clk,
  input logic              rst_n,
  nb_sign_unit_seq_if.slave bus
);
  localparam int K  = N / W;
  localparam int CW = $clog2(K + 1);

  if (N % W != 0) begin : g_bad_w
    $error("nb_sign_unit_seq: N must be a multiple of W");
  end

  state_t        state, nxt;
  logic [N-1:0]  opr, res, res_nxt;
  logic          carry, cplm, ovf_r;
  logic [CW-1:0] cnt;
  logic [W-1:0]  r;
  logic          cout;
  logic          last, cplm_ld, ovf_ld;

  assign last    = (cnt == CW'(K - 1));
  // Complement on negate, or on abs of a negative operand.
  assign cplm_ld = (bus.mode == MODE_NEG) | ((bus.mode == MODE_ABS) & bus.a[N-1]);
  // Most-negative value has no positive counterpart; the ripple leaves it unchanged.
  assign ovf_ld  = cplm_ld & (bus.a == {1'b1, {(N-1){1'b0}}});

  nb_digit_cinc #(.W(W)) u_digit (
    .d    (opr[W-1:0]),
    .inv  (cplm),
    .cin  (carry),
    .r    (r),
    .cout (cout)
  );

  // Result fills from the MSB end so after K digits the word is aligned.
  if (W == N) begin : g_one_digit
    assign res_nxt = r;
  end else begin : g_multi_digit
    assign res_nxt = {r, res[N-1:W]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt           = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst_n so the unit never advertises ready while held in reset.
        bus.in_ready = rst_n;
        if (bus.in_valid) nxt = BUSY;
      end
      BUSY: if (last) nxt = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opr   <= '0;
      res   <= '0;
      carry <= 1'b0;
      cplm  <= 1'b0;
      ovf_r <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          opr   <= bus.a;
          cplm  <= cplm_ld;
          carry <= cplm_ld;
          ovf_r <= ovf_ld;
          cnt   <= '0;
        end
        BUSY: begin
          carry <= cout;
          opr   <= opr >> W;
          res   <= res_nxt;
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.y    = res;
  assign bus.ovf  = bus.out_valid & ovf_r;
  assign bus.zero = bus.out_valid & ~|res;
endmodule

// File: tb/tb_nb_sign_unit_seq.sv
// tb_nb_sign_unit_seq: directed checks of the sign unit in three builds
// (N=5/W=1, N=8/W=4, N=5/W=5) plus an exhaustive N=5 sweep with gaps.
module tb_nb_sign_unit_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       iv[3];
  logic [7:0] av[3];
  logic [1:0] md[3];
  logic       ordy[3];
  logic       ir[3], ov[3], of[3], zr[3];
  logic [7:0] yo[3];
  int         kk[3];
  int         nn[3];

  int n_cmp = 0;
  int n_err = 0;

  nb_sign_unit_seq_if #(.N(5)) if0 ();
  nb_sign_unit_seq_if #(.N(8)) if1 ();
  nb_sign_unit_seq_if #(.N(5)) if2 ();

  nb_sign_unit_seq #(.N(5), .W(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  nb_sign_unit_seq #(.N(8), .W(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  nb_sign_unit_seq #(.N(5), .W(5)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.in_valid = iv[0];   assign if0.a = av[0][4:0];
  assign if0.mode = md[0];       assign if0.out_ready = ordy[0];
  assign ir[0] = if0.in_ready;   assign ov[0] = if0.out_valid;
  assign of[0] = if0.ovf;        assign zr[0] = if0.zero;
  assign yo[0] = {3'b000, if0.y};

  assign if1.in_valid = iv[1];   assign if1.a = av[1];
  assign if1.mode = md[1];       assign if1.out_ready = ordy[1];
  assign ir[1] = if1.in_ready;   assign ov[1] = if1.out_valid;
  assign of[1] = if1.ovf;        assign zr[1] = if1.zero;
  assign yo[1] = if1.y;

  assign if2.in_valid = iv[2];   assign if2.a = av[2][4:0];
  assign if2.mode = md[2];       assign if2.out_ready = ordy[2];
  assign ir[2] = if2.in_ready;   assign ov[2] = if2.out_valid;
  assign of[2] = if2.ovf;        assign zr[2] = if2.zero;
  assign yo[2] = {3'b000, if2.y};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Reference: modular negation of the N-bit word, independent of the digit ripple.
  task automatic ref_op(input int n, input logic [7:0] a, input logic [1:0] m,
                        output logic [7:0] y, output logic o);
    logic [7:0] mask;
    logic       c;
    mask = 8'((1 << n) - 1);
    c    = (m == 2'b01) || ((m == 2'b10) && a[n-1]);
    y    = c ? (8'(-a) & mask) : a;
    o    = c && (a == 8'(1 << (n - 1)));
  endtask

  // Entered and left at a negedge; returns edges from accept to out_valid.
  task automatic start_op(input int u, input logic [7:0] a, input logic [1:0] m,
                          output int lat);
    int t;
    t = 0;
    while (!ir[u] && t < 50) begin
      @(posedge clk); @(negedge clk); t++;
    end
    if (t >= 50) chk("ready_timeout", 32'(ir[u]), 32'd1);
    iv[u] = 1'b1; av[u] = a; md[u] = m;
    @(posedge clk);
    #1 iv[u] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); lat++; @(negedge clk);
    end while (!ov[u] && lat < 50);
    if (!ov[u]) chk("valid_timeout", 32'(ov[u]), 32'd1);
  endtask

  task automatic finish_op(input int u);
    ordy[u] = 1'b1;
    @(posedge clk); @(negedge clk);
    ordy[u] = 1'b0;
    chk("ready_after_take", 32'(ir[u]), 32'd1);
    chk("valid_after_take", 32'(ov[u]), 32'd0);
  endtask

  task automatic do_op(input string tag, input int u, input logic [7:0] a,
                       input logic [1:0] m, input logic [7:0] ey, input logic eo,
                       input logic ez);
    int lat;
    start_op(u, a, m, lat);
    chk({tag, ".lat"},  32'(lat), 32'(kk[u]));
    chk({tag, ".y"},    32'(yo[u]), 32'(ey));
    chk({tag, ".ovf"},  32'(of[u]), 32'(eo));
    chk({tag, ".zero"}, 32'(zr[u]), 32'(ez));
    finish_op(u);
  endtask

  initial begin
    int         lat;
    logic [7:0] y0, ey;
    logic       eo;
    kk = '{5, 2, 1};
    nn = '{5, 8, 5};
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; av[i] = '0; md[i] = '0; ordy[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready",  32'(ir[0]), 32'd0);
    chk("rst.out_valid", 32'(ov[0]), 32'd0);
    chk("rst.y",         32'(yo[0]), 32'd0);
    chk("rst.ovf",       32'(of[0]), 32'd0);
    chk("rst.zero",      32'(zr[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rel.in_ready", 32'(ir[0]), 32'd1);

    // N=5, W=1 directed
    do_op("neg3",   0, 8'h03, 2'b01, 8'h1D, 1'b0, 1'b0);
    do_op("absmin", 0, 8'h10, 2'b10, 8'h10, 1'b1, 1'b0);
    do_op("passmn", 0, 8'h10, 2'b00, 8'h10, 1'b0, 1'b0);
    do_op("neg0",   0, 8'h00, 2'b01, 8'h00, 1'b0, 1'b1);
    do_op("absneg", 0, 8'h1B, 2'b10, 8'h05, 1'b0, 1'b0);
    do_op("rsvd",   0, 8'h1B, 2'b11, 8'h1B, 1'b0, 1'b0);

    // N=8, W=4 directed and backpressure
    do_op("w4min", 1, 8'h80, 2'b01, 8'h80, 1'b1, 1'b0);
    start_op(1, 8'h01, 2'b01, lat);
    chk("w4neg1.lat", 32'(lat), 32'd2);
    y0 = yo[1];
    chk("w4neg1.y", 32'(y0), 32'hFF);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      if (yo[1] !== y0 || !ov[1] || ir[1]) chk("hold", {yo[1], 7'd0, ov[1], 7'd0, ir[1]}, {y0, 16'h0100});
    end
    chk("hold.y",        32'(yo[1]), 32'hFF);
    chk("hold.valid",    32'(ov[1]), 32'd1);
    chk("hold.in_ready", 32'(ir[1]), 32'd0);
    finish_op(1);

    // Reset during the third BUSY cycle
    iv[0] = 1'b1; av[0] = 8'h03; md[0] = 2'b01;
    @(posedge clk);
    #1 iv[0] = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort.out_valid", 32'(ov[0]), 32'd0);
    chk("abort.y",         32'(yo[0]), 32'd0);
    chk("abort.in_ready",  32'(ir[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort.rel_ready", 32'(ir[0]), 32'd1);
    do_op("postrst", 0, 8'h07, 2'b01, 8'h19, 1'b0, 1'b0);

    // Exhaustive N=5 sweep, W=1 and W=5, random gaps on both sides
    foreach (nn[u]) begin
      if (u == 1) continue;
      for (int a = 0; a < 32; a++) begin
        for (int m = 0; m < 4; m++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          ref_op(5, 8'(a), 2'(m), ey, eo);
          start_op(u, 8'(a), 2'(m), lat);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          chk("sweep.lat",  32'(lat), 32'(kk[u]));
          chk("sweep.y",    32'(yo[u]), 32'(ey));
          chk("sweep.ovf",  32'(of[u]), 32'(eo));
          chk("sweep.zero", 32'(zr[u]), 32'(ey == 8'h00));
          finish_op(u);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
